// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared state type and counter width helpers for the PLL supervisor
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAULT
    } sup_state_t;

    // Width of a counter that walks 0..bound-1; never narrower than one bit.
    function automatic int cnt_w(input int bound);
        return (bound <= 2) ? 1 : $clog2(bound);
    endfunction

    // Width of a register that must hold the value max_val itself.
    function automatic int val_w(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - parametrised-depth synchroniser for one asynchronous bit
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_supervisor.sv
// rtl/pll_supervisor.sv - PLL reset pulse, lock qualification, retry and staggered domain release
module pll_supervisor
    import pll_sup_pkg::*;
#(
    parameter int N_DOM        = 4,
    parameter int PLL_RST_CYC  = 32,
    parameter int LOCK_TIMEOUT = 270000,
    parameter int LOCK_STABLE  = 1024,
    parameter int STAGGER      = 16,
    parameter int MAX_RETRY    = 3,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                             clkin,
    input  logic                             rst_n,
    input  logic                             pll_lock_i,
    input  logic                             relock_req_i,
    output logic                             pll_rst_o,
    output logic [N_DOM-1:0]                 dom_rst_n_o,
    output logic                             ready_o,
    output logic                             fault_o,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt_o
);

    localparam int RW    = $clog2(MAX_RETRY + 1);
    localparam int RST_W = cnt_w(PLL_RST_CYC);
    localparam int TO_W  = cnt_w(LOCK_TIMEOUT);
    localparam int STB_W = cnt_w(LOCK_STABLE);
    localparam int STG_W = cnt_w(STAGGER);
    localparam int IDX_W = cnt_w(N_DOM);

    localparam logic [RST_W-1:0] RST_LAST    = RST_W'(PLL_RST_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST    = STB_W'(LOCK_STABLE - 1);
    localparam logic [STG_W-1:0] STG_LAST    = STG_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_DOM - 1);
    localparam logic [RW-1:0]    RETRY_LIMIT = RW'(MAX_RETRY);

    sup_state_t       state;
    logic [RST_W-1:0] rst_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [STB_W-1:0] stb_cnt;
    logic [STG_W-1:0] stg_cnt;
    logic [IDX_W-1:0] dom_idx;
    logic             lock_s;
    logic             restart;
    logic [RW-1:0]    retry_next;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (pll_lock_i),
        .q     (lock_s)
    );

    // Lock loss once domains are being released, or a re-lock request in RUN,
    // restarts the whole sequence without counting as a failed attempt.
    assign restart = ((state == RELEASE) && !lock_s) ||
                     ((state == RUN) && (!lock_s || relock_req_i));

    assign retry_next = retry_cnt_o + 1'b1;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PLL_RST;
            rst_cnt     <= '0;
            to_cnt      <= '0;
            stb_cnt     <= '0;
            stg_cnt     <= '0;
            dom_idx     <= '0;
            pll_rst_o   <= 1'b1;
            dom_rst_n_o <= '0;
            ready_o     <= 1'b0;
            fault_o     <= 1'b0;
            retry_cnt_o <= '0;
        end else begin
            // Counters idle at zero outside their own state, so every entry starts from 0.
            rst_cnt <= '0;
            to_cnt  <= '0;
            stb_cnt <= '0;
            stg_cnt <= '0;
            dom_idx <= '0;

            if (restart) begin
                state       <= PLL_RST;
                pll_rst_o   <= 1'b1;
                dom_rst_n_o <= '0;
                ready_o     <= 1'b0;
            end else begin
                case (state)
                    PLL_RST: begin
                        if (rst_cnt == RST_LAST) begin
                            state     <= WAIT_LOCK;
                            pll_rst_o <= 1'b0;
                        end else begin
                            rst_cnt <= rst_cnt + 1'b1;
                        end
                    end

                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= STABLE;
                        end else if (to_cnt == TO_LAST) begin
                            retry_cnt_o <= retry_next;
                            pll_rst_o   <= 1'b1;
                            if (retry_next == RETRY_LIMIT) begin
                                state   <= FAULT;
                                fault_o <= 1'b1;
                            end else begin
                                state <= PLL_RST;
                            end
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end

                    STABLE: begin
                        if (!lock_s) begin
                            state <= WAIT_LOCK;
                        end else if (stb_cnt == STB_LAST) begin
                            state <= RELEASE;
                        end else begin
                            stb_cnt <= stb_cnt + 1'b1;
                        end
                    end

                    RELEASE: begin
                        if (stg_cnt == STG_LAST) begin
                            dom_rst_n_o[dom_idx] <= 1'b1;
                            if (dom_idx == IDX_LAST) begin
                                state       <= RUN;
                                ready_o     <= 1'b1;
                                retry_cnt_o <= '0;
                            end else begin
                                dom_idx <= dom_idx + 1'b1;
                            end
                        end else begin
                            stg_cnt <= stg_cnt + 1'b1;
                            dom_idx <= dom_idx;
                        end
                    end

                    RUN: begin
                        ready_o <= 1'b1;
                    end

                    FAULT: begin
                        pll_rst_o   <= 1'b1;
                        dom_rst_n_o <= '0;
                        ready_o     <= 1'b0;
                        fault_o     <= 1'b1;
                    end

                    default: begin
                        state       <= PLL_RST;
                        pll_rst_o   <= 1'b1;
                        dom_rst_n_o <= '0;
                        ready_o     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_supervisor.sv
// tb/tb_pll_supervisor.sv - self-checking bench for pll_supervisor
`timescale 1ns/1ps
module tb_pll_supervisor;

    localparam int N_DOM        = 4;
    localparam int PLL_RST_CYC  = 4;
    localparam int LOCK_TIMEOUT = 50;
    localparam int LOCK_STABLE  = 8;
    localparam int STAGGER      = 3;
    localparam int MAX_RETRY    = 3;
    localparam int SYNC_STAGES  = 2;
    localparam int RW           = $clog2(MAX_RETRY + 1);
    localparam int OW           = N_DOM + 3 + RW;

    localparam int PH_RST = 0, PH_WAIT = 1, PH_STABLE = 2, PH_RELEASE = 3, PH_RUN = 4, PH_FAULT = 5;

    logic             clkin = 1'b0;
    logic             rst_n = 1'b1;
    logic             pll_lock_i = 1'b0;
    logic             relock_req_i = 1'b0;
    logic             pll_rst_o;
    logic [N_DOM-1:0] dom_rst_n_o;
    logic             ready_o;
    logic             fault_o;
    logic [RW-1:0]    retry_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clkin = ~clkin;

    pll_supervisor #(
        .N_DOM        (N_DOM),
        .PLL_RST_CYC  (PLL_RST_CYC),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .LOCK_STABLE  (LOCK_STABLE),
        .STAGGER      (STAGGER),
        .MAX_RETRY    (MAX_RETRY),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .clkin        (clkin),
        .rst_n        (rst_n),
        .pll_lock_i   (pll_lock_i),
        .relock_req_i (relock_req_i),
        .pll_rst_o    (pll_rst_o),
        .dom_rst_n_o  (dom_rst_n_o),
        .ready_o      (ready_o),
        .fault_o      (fault_o),
        .retry_cnt_o  (retry_cnt_o)
    );

    // Reference model: phase plus elapsed cycles in that phase; outputs derived arithmetically.
    int   m_phase;
    int   m_t;
    int   m_retries;
    logic m_pipe [SYNC_STAGES];

    task automatic model_reset();
        m_phase   = PH_RST;
        m_t       = 0;
        m_retries = 0;
        for (int i = 0; i < SYNC_STAGES; i++) m_pipe[i] = 1'b0;
    endtask

    task automatic enter(input int p);
        m_phase = p;
        m_t     = 0;
    endtask

    task automatic model_step(input logic lock, input logic relock);
        logic ls;
        ls = m_pipe[SYNC_STAGES-1];
        for (int i = SYNC_STAGES - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = lock;
        m_t++;
        case (m_phase)
            PH_RST:     if (m_t == PLL_RST_CYC) enter(PH_WAIT);
            PH_WAIT: begin
                if (ls) enter(PH_STABLE);
                else if (m_t == LOCK_TIMEOUT) begin
                    m_retries++;
                    enter(m_retries == MAX_RETRY ? PH_FAULT : PH_RST);
                end
            end
            PH_STABLE: begin
                if (!ls) enter(PH_WAIT);
                else if (m_t == LOCK_STABLE) enter(PH_RELEASE);
            end
            PH_RELEASE: begin
                if (!ls) enter(PH_RST);
                else if (m_t == STAGGER * N_DOM) begin
                    m_retries = 0;
                    enter(PH_RUN);
                end
            end
            PH_RUN:     if (!ls || relock) enter(PH_RST);
            default: ;
        endcase
    endtask

    function automatic logic [N_DOM-1:0] m_dom();
        logic [N_DOM-1:0] d;
        d = '0;
        if (m_phase == PH_RUN) d = '1;
        else if (m_phase == PH_RELEASE)
            for (int k = 0; k < N_DOM; k++) if (m_t >= STAGGER * (k + 1)) d[k] = 1'b1;
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] dut_vec();
        return {pll_rst_o, dom_rst_n_o, ready_o, fault_o, retry_cnt_o};
    endfunction

    task automatic model_cmp();
        logic [OW-1:0] e;
        e = {(m_phase == PH_RST) || (m_phase == PH_FAULT), m_dom(),
             m_phase == PH_RUN, m_phase == PH_FAULT, RW'(m_retries)};
        chk("model", 32'(dut_vec()), 32'(e));
    endtask

    task automatic tick();
        @(posedge clkin);
        model_step(pll_lock_i, relock_req_i);
        @(negedge clkin);
        model_cmp();
    endtask

    task automatic do_reset(input string name);
        rst_n        = 1'b0;
        pll_lock_i   = 1'b0;
        relock_req_i = 1'b0;
        #1;
        model_reset();
        chk({name, "_reset_vals"}, 32'(dut_vec()), 32'({1'b1, 4'b0000, 1'b0, 1'b0, 2'b00}));
        @(negedge clkin);
        @(negedge clkin);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int               ticks;
        logic             lock;
        logic             relock;
        logic             pll_rst;
        logic [N_DOM-1:0] dom;
        logic             ready;
        logic             fault;
        logic [RW-1:0]    retry;
        string            name;
    } vec_t;

    vec_t vt [$];

    function automatic vec_t mk(input int t, input logic l, input logic r, input logic p,
                                input logic [N_DOM-1:0] d, input logic y, input string n);
        vec_t v;
        v.ticks = t; v.lock = l; v.relock = r; v.pll_rst = p; v.dom = d; v.ready = y;
        v.fault = 1'b0; v.retry = '0; v.name = n;
        return v;
    endfunction

    initial begin
        // Bring-up, relock request, re-sequence, and lock loss in RUN; counts are edges after reset release.
        vt.push_back(mk(3,  1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, "rst_held"));
        vt.push_back(mk(1,  1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "rst_fall"));
        vt.push_back(mk(10, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "wait_nolock"));
        vt.push_back(mk(13, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "qualifying"));
        vt.push_back(mk(1,  1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, "dom_step0"));
        vt.push_back(mk(2,  1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, "dom_hold0"));
        vt.push_back(mk(1,  1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, "dom_step1"));
        vt.push_back(mk(3,  1'b1, 1'b0, 1'b0, 4'b0111, 1'b0, "dom_step2"));
        vt.push_back(mk(2,  1'b1, 1'b0, 1'b0, 4'b0111, 1'b0, "pre_ready"));
        vt.push_back(mk(1,  1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, "run"));
        vt.push_back(mk(1,  1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, "relock"));
        vt.push_back(mk(3,  1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, "rerst_held"));
        vt.push_back(mk(1,  1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "rerst_fall"));
        vt.push_back(mk(20, 1'b1, 1'b0, 1'b0, 4'b0111, 1'b0, "reseq_partial"));
        vt.push_back(mk(1,  1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, "reseq_run"));
        vt.push_back(mk(2,  1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, "loss_sync"));
        vt.push_back(mk(1,  1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, "loss_drop"));

        #3;
        do_reset("init");
        foreach (vt[i]) begin
            pll_lock_i   = vt[i].lock;
            relock_req_i = vt[i].relock;
            repeat (vt[i].ticks) tick();
            chk(vt[i].name, 32'(dut_vec()),
                32'({vt[i].pll_rst, vt[i].dom, vt[i].ready, vt[i].fault, vt[i].retry}));
        end
        relock_req_i = 1'b0;

        // One-cycle lock glitch in STABLE restarts the full qualification.
        do_reset("glitch");
        pll_lock_i = 1'b1;
        for (int e = 1; e <= 23; e++) begin
            if (e == 9)  pll_lock_i = 1'b0;
            if (e == 10) pll_lock_i = 1'b1;
            tick();
            if (e == 16 || e == 22) chk("glitch_no_release", 32'(dom_rst_n_o), 32'h0);
            if (e == 23) chk("glitch_requalified", 32'({dom_rst_n_o, retry_cnt_o}), 32'({4'b0001, 2'b00}));
        end

        // Three timeouts lead to FAULT; relock requests there are ignored.
        do_reset("timeout");
        for (int e = 1; e <= 182; e++) begin
            relock_req_i = (e > 165) && (e % 4 == 0);
            tick();
            if (e == 53)  chk("to_retry0", 32'(retry_cnt_o), 32'h0);
            if (e == 54)  chk("to_retry1", 32'({pll_rst_o, retry_cnt_o}), 32'({1'b1, 2'd1}));
            if (e == 107) chk("to_retry1_hold", 32'(retry_cnt_o), 32'h1);
            if (e == 108) chk("to_retry2", 32'({pll_rst_o, retry_cnt_o}), 32'({1'b1, 2'd2}));
            if (e == 161) chk("to_no_fault_yet", 32'(fault_o), 32'h0);
            if (e == 162) chk("to_fault", 32'({fault_o, pll_rst_o, retry_cnt_o}), 32'({1'b1, 1'b1, 2'd3}));
            if (e == 182) chk("fault_held", 32'({fault_o, pll_rst_o, dom_rst_n_o, ready_o}),
                              32'({1'b1, 1'b1, 4'b0000, 1'b0}));
        end
        do_reset("fault_clear");

        // One timeout, then lock loss after two domains released; then rst_n mid-RELEASE.
        for (int e = 1; e <= 96; e++) begin
            pll_lock_i = (e >= 55 && e <= 73) || (e >= 77);
            tick();
            if (e == 73 || e == 75) chk("midrel_two_released", 32'({dom_rst_n_o, retry_cnt_o}), 32'({4'b0011, 2'd1}));
            if (e == 76) chk("midrel_loss", 32'({pll_rst_o, dom_rst_n_o, ready_o, retry_cnt_o}),
                             32'({1'b1, 4'b0000, 1'b0, 2'd1}));
            if (e == 96) chk("midrel2_two_released", 32'({dom_rst_n_o, retry_cnt_o}), 32'({4'b0011, 2'd1}));
        end
        do_reset("midrel_rst");

        // Randomised lock runs and sparse relock pulses against the model.
        for (int r = 0; r < 4; r++) begin
            int hold;
            if (r > 0) do_reset("rand");
            hold = 0;
            for (int c = 0; c < 300; c++) begin
                if (hold == 0) begin
                    pll_lock_i = ($urandom_range(0, 9) < 7);
                    hold = int'($urandom_range(1, 40));
                end
                hold--;
                relock_req_i = ($urandom_range(0, 63) == 0);
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
